per_req_arb_rr_n: RTL and testbench

- N-channel request arbiter and multiplexer for the peripheral interconnect, using grant-based flow control.
- Shares one slave request port between N_CH masters with round-robin priority.
- Supports locked sequences so that atomic or burst traffic from one master is not interleaved.
- Sits between the PE-side request ports and a single peripheral target; replaces cascaded two-input request muxes for N_CH > 2.

---
 rtl/per_interco_pkg.sv | 14 +
 rtl/rr_prio_encoder.sv | 38 +++
 rtl/per_req_arb_rr_n.sv | 130 +++++++++++++
 tb/tb_per_req_arb_rr_n.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/per_interco_pkg.sv
// Shared definitions for the peripheral interconnect arbiters: the lock FSM
// encoding and the round-robin index increment.
package per_interco_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_encoder.sv
// Round-robin priority encoder: the first set request at or above ptr_i, with
// wrap-around, found by searching a doubled request vector.
module rr_prio_encoder #(
  parameter int N_CH  = 4,
  parameter int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N_CH-1:0] req_dbl;
  logic [2*N_CH-1:0] req_masked;

  // The lower copy only keeps bits at or above the pointer. The upper copy
  // supplies the wrapped-around channels.
  always_comb begin
    req_dbl    = {req_i, req_i};
    req_masked = '0;
    for (int i = 0; i < 2*N_CH; i++) begin
      req_masked[i] = req_dbl[i] && (i >= int'(ptr_i));
    end
  end

  // The loop runs downward, so the lowest set position is assigned last and wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 2*N_CH-1; i >= 0; i--) begin
      if (req_masked[i]) begin
        valid_o = 1'b1;
        idx_o   = (i >= N_CH) ? PTR_W'(i - N_CH) : PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/per_req_arb_rr_n.sv
// N-channel round-robin request arbiter/mux with grant flow control and
// locked (non-interleaved) sequences.
//   state    | meaning
//   UNLOCKED | normal round-robin over all requesters
//   LOCKED   | only lock_owner is eligible until last beat, limit, or abandon
module per_req_arb_rr_n
  import per_interco_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ID_WIDTH   = 20,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int MAX_LOCK   = 16,
  parameter int PTR_W      = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i   [N_CH],
  input  logic [N_CH-1:0]       data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i [N_CH],
  input  logic [BE_WIDTH-1:0]   data_be_i    [N_CH],
  input  logic [ID_WIDTH-1:0]   data_ID_i    [N_CH],
  input  logic [N_CH-1:0]       data_lock_i,
  output logic [N_CH-1:0]       data_gnt_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  input  logic                  data_gnt_i,
  output logic                  lock_active_o,
  output logic [PTR_W-1:0]      lock_owner_o
);

  localparam int LCNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [LCNT_W-1:0] LOCK_LIM = LCNT_W'(MAX_LOCK - 1);

  typedef logic [PTR_W-1:0] ch_idx_t;

  ch_idx_t           rr_ptr_q, rr_ptr_d;
  ch_idx_t           lock_owner_q;
  lock_state_e       lock_state_q;
  logic [LCNT_W-1:0] lock_cnt_q;

  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] owner_mask;
  ch_idx_t         winner;
  ch_idx_t         mux_sel;
  logic            winner_vld;
  logic            hs;

  always_comb begin
    owner_mask               = '0;
    owner_mask[lock_owner_q] = 1'b1;
    eligible = (lock_state_q == LOCKED) ? (data_req_i & owner_mask) : data_req_i;
  end

  rr_prio_encoder #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_prio (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .idx_o   (winner),
    .valid_o (winner_vld)
  );

  // Requests and grants are held off while reset is asserted, so nothing can
  // be granted from the cleared state before reset is released.
  assign data_req_o = rst_n & winner_vld;
  assign hs         = data_req_o & data_gnt_i;
  assign mux_sel    = winner_vld ? winner : rr_ptr_q;
  assign rr_ptr_d   = ch_idx_t'(rr_wrap_inc(32'(winner), N_CH));

  always_comb begin
    data_gnt_o         = '0;
    data_gnt_o[winner] = hs;
  end

  assign data_add_o   = data_add_i[mux_sel];
  assign data_wen_o   = data_wen_i[mux_sel];
  assign data_wdata_o = data_wdata_i[mux_sel];
  assign data_be_o    = data_be_i[mux_sel];
  assign data_ID_o    = data_ID_i[mux_sel];

  assign lock_active_o = (lock_state_q == LOCKED);
  assign lock_owner_o  = lock_owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_state_q <= UNLOCKED;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      if (hs) rr_ptr_q <= rr_ptr_d;
      case (lock_state_q)
        UNLOCKED: begin
          // With MAX_LOCK == 1 every locked beat is also the last one allowed.
          if (hs && data_lock_i[winner] && (MAX_LOCK > 1)) begin
            lock_state_q <= LOCKED;
            lock_owner_q <= winner;
            lock_cnt_q   <= LCNT_W'(1);
          end
        end
        LOCKED: begin
          if (!data_req_i[lock_owner_q]) begin
            lock_state_q <= UNLOCKED;
            lock_cnt_q   <= '0;
          end else if (hs) begin
            if (data_lock_i[lock_owner_q] && (lock_cnt_q < LOCK_LIM)) begin
              lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
            end else begin
              lock_state_q <= UNLOCKED;
              lock_cnt_q   <= '0;
            end
          end
        end
        default: begin
          lock_state_q <= UNLOCKED;
          lock_cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_per_req_arb_rr_n.sv
// Directed bench for per_req_arb_rr_n (N_CH=4, MAX_LOCK=4) with hand-computed
// grant sequences.
module tb_per_req_arb_rr_n;

  localparam int N_CH = 4;
  localparam int IDW  = 20;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BEW  = DW/8;
  localparam int PW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] data_req_i = '0;
  logic [AW-1:0]   data_add_i   [N_CH];
  logic [N_CH-1:0] data_wen_i = 4'b1010;
  logic [DW-1:0]   data_wdata_i [N_CH];
  logic [BEW-1:0]  data_be_i    [N_CH];
  logic [IDW-1:0]  data_ID_i    [N_CH];
  logic [N_CH-1:0] data_lock_i = '0;
  logic [N_CH-1:0] data_gnt_o;
  logic            data_req_o;
  logic [AW-1:0]   data_add_o;
  logic            data_wen_o;
  logic [DW-1:0]   data_wdata_o;
  logic [BEW-1:0]  data_be_o;
  logic [IDW-1:0]  data_ID_o;
  logic            data_gnt_i = 1'b0;
  logic            lock_active_o;
  logic [PW-1:0]   lock_owner_o;

  int checks = 0;
  int errors = 0;

  per_req_arb_rr_n #(
    .N_CH(N_CH), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BE_WIDTH(BEW), .MAX_LOCK(4), .PTR_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_lock_i(data_lock_i), .data_gnt_o(data_gnt_o), .data_req_o(data_req_o),
    .data_add_o(data_add_o), .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o),
    .data_be_o(data_be_o), .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i),
    .lock_active_o(lock_active_o), .lock_owner_o(lock_owner_o)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int c);
    return 32'h4000_0000 + 32'(c) * 32'h10;
  endfunction

  function automatic logic [IDW-1:0] id_of(input int c);
    return 20'h00100 + 20'(c);
  endfunction

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      data_add_i[c]   = addr_of(c);
      data_wdata_i[c] = 32'hD000_0000 | 32'(c);
      data_be_i[c]    = 4'(c + 1);
      data_ID_i[c]    = id_of(c);
    end
  end

  // Master-side rule: payload and lock stay put while a request waits for grant.
  logic [N_CH-1:0] hold_q = '0;
  logic [AW-1:0]   add_q  [N_CH];
  logic [N_CH-1:0] lock_q = '0;
  always @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (rst_n && hold_q[c] && data_req_i[c]) begin
        assert (data_add_i[c] == add_q[c] && data_lock_i[c] == lock_q[c])
          else $error("protocol: ch%0d payload changed while waiting", c);
      end
      hold_q[c] <= rst_n && data_req_i[c] && !data_gnt_o[c];
      add_q[c]  <= data_add_i[c];
      lock_q[c] <= data_lock_i[c];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; data_req_i = '0; data_lock_i = '0; data_gnt_i = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_req_i = '0; data_lock_i = '0; data_gnt_i = 1'b0;
    @(negedge clk);
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", data_req_o); end
    checks++; if (data_gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", data_gnt_o); end
    checks++; if (lock_active_o !== 1'b0) begin errors++; $display("FAIL reset_lock_active got %b want 0", lock_active_o); end
    checks++; if (lock_owner_o !== 2'd0) begin errors++; $display("FAIL reset_lock_owner got %0d want 0", lock_owner_o); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (data_add_o !== addr_of(0)) begin errors++; $display("FAIL idle_payload got %h want %h", data_add_o, addr_of(0)); end
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", data_req_o); end
  endtask

  task automatic test_rr_all();
    logic [N_CH-1:0] exp;
    do_reset();
    data_req_i = 4'b1111; data_gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++; if (data_gnt_o !== exp) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", k, data_gnt_o, exp); end
      checks++; if (data_ID_o !== id_of(k % 4)) begin errors++; $display("FAIL rr_id%0d got %h want %h", k, data_ID_o, id_of(k % 4)); end
      tick();
    end
    // Five grants leave the pointer at 1, so ch1 wins over ch0 and ch2.
    data_req_i = 4'b0111;
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b0010) begin errors++; $display("FAIL rr_ptr_after got %b want 0010", data_gnt_o); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    data_req_i = 4'b1010; data_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) data_gnt_i = 1'b1;
      @(negedge clk);
      checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL stall_req%0d got %b want 1", k, data_req_o); end
      checks++; if (data_add_o !== addr_of(1)) begin errors++; $display("FAIL stall_add%0d got %h want %h", k, data_add_o, addr_of(1)); end
      checks++; if (data_gnt_o !== (k == 3 ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL stall_gnt%0d got %b", k, data_gnt_o); end
      tick();
    end
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b1000) begin errors++; $display("FAIL stall_next got %b want 1000", data_gnt_o); end
    tick();
  endtask

  task automatic test_lock_seq();
    do_reset();
    data_gnt_i = 1'b1; data_req_i = 4'b0011;
    tick(); tick();
    data_req_i = 4'b1111; data_lock_i = 4'b0100;
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b0100) begin errors++; $display("FAIL lock_beat0 got %b want 0100", data_gnt_o); end
    tick();
    for (int k = 1; k < 3; k++) begin
      if (k == 2) data_lock_i = 4'b0000;
      @(negedge clk);
      checks++; if (data_gnt_o !== 4'b0100) begin errors++; $display("FAIL lock_beat%0d got %b want 0100", k, data_gnt_o); end
      checks++; if (lock_active_o !== 1'b1) begin errors++; $display("FAIL lock_active%0d got %b want 1", k, lock_active_o); end
      checks++; if (lock_owner_o !== 2'd2) begin errors++; $display("FAIL lock_owner%0d got %0d want 2", k, lock_owner_o); end
      tick();
    end
    @(negedge clk);
    checks++; if (lock_active_o !== 1'b0) begin errors++; $display("FAIL lock_released got %b want 0", lock_active_o); end
    checks++; if (data_gnt_o !== 4'b1000) begin errors++; $display("FAIL lock_next got %b want 1000", data_gnt_o); end
    tick();
  endtask

  task automatic test_max_lock();
    do_reset();
    data_gnt_i = 1'b1; data_req_i = 4'b0011; data_lock_i = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL maxlock_beat%0d got %b want 0001", k, data_gnt_o); end
      checks++; if (lock_active_o !== (k != 0)) begin errors++; $display("FAIL maxlock_active%0d got %b", k, lock_active_o); end
      tick();
    end
    @(negedge clk);
    checks++; if (lock_active_o !== 1'b0) begin errors++; $display("FAIL maxlock_release got %b want 0", lock_active_o); end
    checks++; if (data_gnt_o !== 4'b0010) begin errors++; $display("FAIL maxlock_ch1 got %b want 0010", data_gnt_o); end
    tick();
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL maxlock_regrant got %b want 0001", data_gnt_o); end
    tick();
    @(negedge clk);
    checks++; if (lock_active_o !== 1'b1 || lock_owner_o !== 2'd0) begin errors++; $display("FAIL maxlock_relock got %b/%0d want 1/0", lock_active_o, lock_owner_o); end
    data_req_i = '0; data_lock_i = '0;
    tick();
  endtask

  task automatic test_abandon();
    do_reset();
    data_gnt_i = 1'b1; data_req_i = 4'b0010; data_lock_i = 4'b0010;
    tick();
    data_req_i = 4'b0110;
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b0010) begin errors++; $display("FAIL abandon_owner got %b want 0010", data_gnt_o); end
    tick();
    data_req_i = 4'b0100;
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b0000 || data_req_o !== 1'b0) begin errors++; $display("FAIL abandon_nogrant got %b/%b want 0000/0", data_gnt_o, data_req_o); end
    tick();
    @(negedge clk);
    checks++; if (lock_active_o !== 1'b0) begin errors++; $display("FAIL abandon_unlock got %b want 0", lock_active_o); end
    checks++; if (data_gnt_o !== 4'b0100) begin errors++; $display("FAIL abandon_ch2 got %b want 0100", data_gnt_o); end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    data_gnt_i = 1'b1; data_req_i = 4'b0001; data_lock_i = 4'b0001;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (lock_active_o !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b want 0", lock_active_o); end
    checks++; if (data_gnt_o !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got %b want 0000", data_gnt_o); end
    checks++; if (lock_owner_o !== 2'd0) begin errors++; $display("FAIL rstmid_owner got %0d want 0", lock_owner_o); end
    rst_n = 1'b1; data_req_i = 4'b1111; data_lock_i = '0;
    @(negedge clk);
    checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL rstmid_first got %b want 0001", data_gnt_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_stall();
    test_lock_seq();
    test_max_lock();
    test_abandon();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
